// File: rtl/key_press_decoder_if.sv
// Key event bundle between a debounced key source and its press decoder.
interface key_press_decoder_if;
    logic key_flag;
    logic key_state;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic double_pulse;
    logic key_held;

    // Debouncer / control side: supplies key events, observes classifications.
    modport master (
        output key_flag,
        output key_state,
        input  short_pulse,
        input  long_pulse,
        input  repeat_pulse,
        input  double_pulse,
        input  key_held
    );

    // Decoder side: consumes key events, produces classifications.
    modport slave (
        input  key_flag,
        input  key_state,
        output short_pulse,
        output long_pulse,
        output repeat_pulse,
        output double_pulse,
        output key_held
    );
endinterface

// File: rtl/key_press_decoder.sv
// Classifies debounced key activity into short, long (with auto-repeat) and
// double-click events, each reported as a one-cycle registered pulse.
module key_press_decoder #(
    parameter int unsigned LONG_CYC   = 50_000_000,
    parameter int unsigned REPEAT_CYC = 10_000_000,
    parameter int unsigned DCLICK_CYC = 15_000_000,
    parameter int unsigned CNT_W      = 26
) (
    input  logic                clk,
    input  logic                rst,
    key_press_decoder_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRESS1 = 3'd1,
        S_LONG   = 3'd2,
        S_WAIT2  = 3'd3,
        S_PRESS2 = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              short_d, long_d, repeat_d, double_d, held_d;
    logic              short_q, long_q, repeat_q, double_q, held_q;
    logic              press_c, release_c;

    // Edge events decoded straight from the debouncer outputs.
    assign press_c   = bus.key_flag & ~bus.key_state;
    assign release_c = bus.key_flag &  bus.key_state;

    // Next-state, counter and pulse decisions; release/press win ties with timeouts.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        double_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (press_c) begin
                    state_d = S_PRESS1;
                end
            end
            S_PRESS1: begin
                if (release_c) begin
                    state_d = S_WAIT2;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = S_LONG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LONG: begin
                if (release_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT2: begin
                if (press_c) begin
                    double_d = 1'b1;
                    state_d  = S_PRESS2;
                    cnt_d    = '0;
                end else if (cnt_q == DCLICK_LAST) begin
                    short_d = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_PRESS2: begin
                cnt_d = '0;
                if (release_c) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == S_PRESS1) || (state_d == S_LONG) || (state_d == S_PRESS2);
    end

    // State, counter and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            repeat_q <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            repeat_q <= repeat_d;
            double_q <= double_d;
            held_q   <= held_d;
        end
    end

    assign bus.short_pulse  = short_q;
    assign bus.long_pulse   = long_q;
    assign bus.repeat_pulse = repeat_q;
    assign bus.double_pulse = double_q;
    assign bus.key_held     = held_q;

endmodule
